restoring_divider: RTL and testbench
====================================

// Module: restoring_divider
// PURPOSE
//   Sequential unsigned restoring divider; the division counterpart of the shift-add
//   multiplier datapath. Remainder/quotient pair {A,Q} shifts LEFT one bit per cycle.
//   A trial subtract of the divisor M follows each shift. A negative result restores A
//   and writes quotient bit 0; a non-negative result keeps the difference and writes 1.
//   Sits beside the multiplier in the ALU lab datapath and is driven by the same controller.
// PARAMETERS
//   WIDTH   4   operand width in bits (dividend, divisor, quotient, remainder); >= 2
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  unsigned dividend, captured when start is accepted
//   divisor      in   WIDTH  unsigned divisor, captured when start is accepted
//   busy         out  1      high whenever state != IDLE
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  unsigned quotient
//   remainder    out  WIDTH  unsigned remainder
//   div_by_zero  out  1      divisor was 0 for the current result
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
//     All internal A/Q/M/count registers are cleared.
//   FSM: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//     IDLE: start=1 and divisor!=0 -> load Q=dividend, M=divisor, A=0 (WIDTH+1 bits),
//       count=0; go to RUN; clear div_by_zero.
//     IDLE: start=1 and divisor==0 -> quotient={WIDTH{1}}, remainder=dividend,
//       div_by_zero=1; go to DONE.
//     RUN: each cycle, {A,Q} <<= 1 and T = A - {1'b0,M} (WIDTH+1 bit arithmetic).
//       T[WIDTH]=1: A unchanged (restore), Q[0]=0.
//       Otherwise: A=T, Q[0]=1.
//       count++; after WIDTH steps go to DONE and latch quotient=Q, remainder=A[WIDTH-1:0].
//     DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
//   Timing: start high in cycle 0 (accepted).
//     Normal operation: busy high in cycles 1..WIDTH+1; done high in cycle WIDTH+1.
//     Divide by zero: busy and done high in cycle 1 only.
//   Hold: quotient, remainder and div_by_zero hold until the next accepted start.
//     They do not change during RUN; internal A/Q are separate from the output registers.
//   start in RUN or DONE is ignored. It is not queued; the requester re-asserts in IDLE.
//   dividend/divisor changes after acceptance have no effect.
//   Invariant: dividend == quotient*divisor + remainder and remainder < divisor (divisor!=0).
//   rst mid-operation: next cycle is IDLE with reset values; no done pulse is produced.
//   rst and start in the same cycle: rst wins; start is dropped.
// STRUCTURE
//   Shared package: WIDTH default, state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2),
//     count width $clog2(WIDTH+1).
//   Sub-module lshift_reg: (2*WIDTH+1)-bit left shift register with parallel load and a
//     serial-in LSB. Serial input is the quotient bit; a separate load port writes A.
//     This mirrors the multiplier's right shift register.
//   Top level holds the FSM, counter, subtractor and output registers.
// TESTING (WIDTH=4)
//   1. start, 13/4 -> done in cycle 5, quotient=3, remainder=1, div_by_zero=0,
//      busy high in cycles 1-5.
//   2. start, 15/1 -> quotient=15, remainder=0; then 0/7 -> quotient=0, remainder=0.
//   3. start, 9/0 -> done in cycle 1, div_by_zero=1, quotient=15, remainder=9; then
//      6/3 -> quotient=2, remainder=0, div_by_zero=0.
//   4. start 7/2; start pulsed again in cycles 2 and 5 with 15/15 -> single result
//      quotient=3, remainder=1; no second done.
//   5. start 14/3, assert rst in cycle 3 -> busy=0, outputs=0 from cycle 4, no done pulse;
//      then 14/3 -> quotient=4, remainder=2.
//   6. Exhaustive: all 256 dividend/divisor pairs, checked against a reference model,
//      including the divide-by-zero rule.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider_pkg
//  Purpose  : Shared definitions for the restoring divider slice.
//             - c_default_width : default operand width
//             - state_t         : controller state encoding
//             - count_width()   : step-counter width for a given operand width
//  Revision : 1.0 - initial release
// ============================================================================
package restoring_divider_pkg;

    localparam int unsigned c_default_width = 4;
    localparam int unsigned c_state_w       = 2;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must be able to hold WIDTH itself (one past the last step).
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider_if
//  Purpose  : Request/result bundle between the ALU-lab controller and the
//             restoring divider.
//  Signals  : start, dividend, divisor          (controller -> divider)
//             busy, done, quotient, remainder,
//             div_by_zero                       (divider -> controller)
//  Modports : master = controller side, slave = divider side
//  Revision : 1.0 - initial release
// ============================================================================
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/restoring_divider_lshift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : lshift_reg
//  Purpose  : (2*WIDTH+1)-bit left shift register holding the partial
//             remainder A (upper WIDTH+1 bits) and quotient Q (lower WIDTH
//             bits). Parallel load, serial-in LSB, and a separate A write
//             that lands together with a shift.
//  Ports    : clk, rst      clock / synchronous active-high reset
//             i_load        parallel load of the whole register (priority)
//             i_load_val    parallel load value
//             i_shift       shift left one bit, i_serial enters the LSB
//             i_serial      serial input (new quotient bit)
//             i_a_load      write i_a_val into the A field
//             i_a_val       new A value (WIDTH+1 bits)
//             o_data        register contents {A, Q}
//  Revision : 1.0 - initial release
// ============================================================================
module lshift_reg
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [2*WIDTH:0]   i_load_val,
    input  logic               i_shift,
    input  logic               i_serial,
    input  logic               i_a_load,
    input  logic [WIDTH:0]     i_a_val,
    output logic [2*WIDTH:0]   o_data
);

    logic [2*WIDTH:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_val;
        end else if (i_shift) begin
            // With i_a_load the A field takes the externally computed value
            // (the shifted-and-possibly-subtracted remainder) in the same edge.
            if (i_a_load) begin
                r_data <= {i_a_val, r_data[WIDTH-2:0], i_serial};
            end else begin
                r_data <= {r_data[2*WIDTH-1:0], i_serial};
            end
        end else if (i_a_load) begin
            r_data[2*WIDTH:WIDTH] <= i_a_val;
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : restoring_divider
//  Purpose  : Sequential unsigned restoring divider. {A,Q} shifts left one
//             bit per step, the divisor is trial-subtracted from A; a negative
//             result restores A and shifts in 0, otherwise A keeps the
//             difference and 1 is shifted in. WIDTH steps per division.
//  Ports    : clk   rising-edge clock
//             rst   synchronous active-high reset
//             bus   restoring_divider_if.slave (start/dividend/divisor in;
//                   busy/done/quotient/remainder/div_by_zero out, all
//                   registered)
//  Revision : 1.0 - initial release
// ============================================================================
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = c_default_width
) (
    input  logic                 clk,
    input  logic                 rst,
    restoring_divider_if.slave   bus
);

    localparam int unsigned     c_cnt_w = count_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH:0]     w_aq;

    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_dbz;

    logic                 w_accept;
    logic                 w_zero;
    logic                 w_load;
    logic                 w_step;
    logic [WIDTH+1:0]     w_shift_a;
    logic [WIDTH+1:0]     w_trial;
    logic                 w_neg;
    logic [WIDTH:0]       w_a_new;

    // ------------------------------------------------------------------
    // Datapath: trial subtract on the shifted partial remainder.
    // The extra top bit keeps the subtraction exact; A never exceeds the
    // divisor between steps, so the result equals WIDTH+1 bit arithmetic.
    // ------------------------------------------------------------------
    assign w_shift_a = w_aq[2*WIDTH:WIDTH-1];
    assign w_trial   = w_shift_a - {2'b00, r_m};
    assign w_neg     = w_trial[WIDTH+1];
    assign w_a_new   = w_neg ? w_shift_a[WIDTH:0] : w_trial[WIDTH:0];

    assign w_zero    = (bus.divisor == '0);
    assign w_load    = w_accept && !w_zero;
    assign w_step    = (r_state == ST_RUN);

    lshift_reg #(
        .WIDTH      (WIDTH)
    ) u_aq (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val ({{(WIDTH+1){1'b0}}, bus.dividend}),
        .i_shift    (w_step),
        .i_serial   (~w_neg),
        .i_a_load   (w_step),
        .i_a_val    (w_a_new),
        .o_data     (w_aq)
    );

    // ------------------------------------------------------------------
    // Controller: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == c_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Controller: state, counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_m     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Outputs track the state being entered so they are registered
            // yet aligned with it.
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_DONE);

            if (w_accept) begin
                if (w_zero) begin
                    r_quot <= '1;
                    r_rem  <= bus.dividend;
                    r_dbz  <= 1'b1;
                end else begin
                    r_m     <= bus.divisor;
                    r_count <= '0;
                    r_dbz   <= 1'b0;
                end
            end else if (w_step) begin
                r_count <= r_count + c_cnt_w'(1);
                // Final step: capture the values being written into {A,Q}.
                if (r_count == c_last) begin
                    r_quot <= {w_aq[WIDTH-2:0], ~w_neg};
                    r_rem  <= w_a_new[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_restoring_divider
//  Purpose  : Directed and exhaustive self-checking bench for the WIDTH=4
//             restoring divider. Cycle 0 is the cycle in which start is
//             sampled; cycle k is observed at the falling edge after the k-th
//             following rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;

    restoring_divider_if #(.WIDTH(4)) bus ();

    restoring_divider #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          lat;
    int          done_cnt;
    logic [31:0] busy_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch a fixed 12-cycle window. Operands are
    // scrambled right after acceptance; the result must not depend on them.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        lat       = 0;
        done_cnt  = 0;
        busy_mask = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start    = 1'b0;
                bus.dividend = ~a;
                bus.divisor  = ~b;
            end
            if (bus.busy === 1'b1) busy_mask[c] = 1'b1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
        end
    endtask

    task automatic expect_res(input string tag, input logic [3:0] q, input logic [3:0] r,
                              input logic z, input int l, input logic [31:0] bm);
        check({tag, " lat"},  lat,               l);
        check({tag, " ndone"}, done_cnt,         1);
        check({tag, " busy"}, busy_mask,         bm);
        check({tag, " quot"}, bus.quotient,      q);
        check({tag, " rem"},  bus.remainder,     r);
        check({tag, " dbz"},  bus.div_by_zero,   z);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", bus.busy,        0);
        check("rst done", bus.done,        0);
        check("rst quot", bus.quotient,    0);
        check("rst rem",  bus.remainder,   0);
        check("rst dbz",  bus.div_by_zero, 0);
        rst = 1'b0;

        // ---------------- 1: 13/4 ----------------
        run_div(4'd13, 4'd4);
        expect_res("t1 13/4", 4'd3, 4'd1, 1'b0, 5, 32'h3E);

        // ---------------- 2: 15/1, 0/7 ----------------
        run_div(4'd15, 4'd1);
        expect_res("t2 15/1", 4'd15, 4'd0, 1'b0, 5, 32'h3E);
        run_div(4'd0, 4'd7);
        expect_res("t2 0/7", 4'd0, 4'd0, 1'b0, 5, 32'h3E);

        // ---------------- 3: 9/0 then 6/3 ----------------
        run_div(4'd9, 4'd0);
        expect_res("t3 9/0", 4'd15, 4'd9, 1'b1, 1, 32'h02);
        run_div(4'd6, 4'd3);
        expect_res("t3 6/3", 4'd2, 4'd0, 1'b0, 5, 32'h3E);

        // ---------------- 4: start re-pulsed during RUN and DONE ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd7; bus.divisor = 4'd2;
        @(posedge clk);
        lat = 0; done_cnt = 0; busy_mask = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_mask[c] = 1'b1;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (lat == 0) lat = c;
            end
            bus.start = (c == 2 || c == 5);
            if (c == 2) begin
                bus.dividend = 4'd15;
                bus.divisor  = 4'd15;
            end
        end
        bus.start = 1'b0;
        expect_res("t4 7/2", 4'd3, 4'd1, 1'b0, 5, 32'h3E);

        // ---------------- 5: reset mid-operation ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd3;
        @(posedge clk);
        done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) done_cnt++;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                check("t5 busy", bus.busy,        0);
                check("t5 done", bus.done,        0);
                check("t5 quot", bus.quotient,    0);
                check("t5 rem",  bus.remainder,   0);
                check("t5 dbz",  bus.div_by_zero, 0);
                rst = 1'b0;
            end
        end
        check("t5 ndone", done_cnt, 0);
        run_div(4'd14, 4'd3);
        expect_res("t5 14/3", 4'd4, 4'd2, 1'b0, 5, 32'h3E);

        // ---------------- 6: exhaustive against reference model ----------------
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b));
                if (b == 0)
                    expect_res($sformatf("ex %0d/%0d", a, b), 4'd15, 4'(a), 1'b1, 1, 32'h02);
                else
                    expect_res($sformatf("ex %0d/%0d", a, b), 4'(a / b), 4'(a % b), 1'b0, 5, 32'h3E);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
